// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types for the intersection request scheduler: direction index,
// direction count and the one-hot scheduler state encoding.
package traffic_sched_pkg;

  localparam int unsigned N_DIR = 4;

  typedef logic [1:0] dir_t;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    OFFER = 3'b010,
    SERVE = 3'b100
  } state_t;

  function automatic logic [N_DIR-1:0] dir_mask(input dir_t d);
    logic [N_DIR-1:0] m;
    m    = '0;
    m[d] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_rr_pick4.sv
// Round-robin picker: returns the first set request bit strictly after
// ptr, wrapping 3->0; ptr itself has the lowest priority.
module rr_pick4
  import traffic_sched_pkg::*;
(
  input  logic [N_DIR-1:0] req,
  input  logic [1:0]       ptr,
  output logic             found,
  output logic [1:0]       idx
);

  dir_t cand;

  // Scan from farthest to nearest offset so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int unsigned i = 0; i < N_DIR; i++) begin
      cand = ptr + dir_t'(N_DIR - i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection request scheduler with ageing and starvation override.
// Optional emergency preemption is built when TRAFFIC_PREEMPT_EN is defined.
module traffic_phase_scheduler
  import traffic_sched_pkg::*;
#(
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned MAX_WAIT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_DIR-1:0] req_i,
  input  logic             grant_ready_i,
  input  logic             phase_done_i,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic             preempt_i,
  input  logic [1:0]       preempt_dir_i,
`endif
  output logic             grant_valid_o,
  output logic [1:0]       grant_dir_o,
  output logic             grant_urgent_o,
  output logic [N_DIR-1:0] pending_o,
  output logic             busy_o
);

  localparam logic [WAIT_W-1:0] URGENT_AGE = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] AGE_MAX    = '1;

  state_t            state;
  dir_t              last_dir;
  logic [N_DIR-1:0]  pending;
  logic [WAIT_W-1:0] age [N_DIR];
  logic [N_DIR-1:0]  urgent;
  logic [N_DIR-1:0]  clr_mask;
  logic              accept;
  logic              update_ptr;
  logic              u_found;
  logic              p_found;
  dir_t              u_idx;
  dir_t              p_idx;
  dir_t              sel_dir;
  logic              sel_urgent;

  assign accept    = (state == OFFER) && grant_ready_i;
  assign clr_mask  = accept ? dir_mask(grant_dir_o) : '0;
  assign pending_o = pending;

  always_comb begin
    urgent = '0;
    for (int unsigned d = 0; d < N_DIR; d++) begin
      urgent[d] = pending[d] && (age[d] >= URGENT_AGE);
    end
  end

  // Clearing on acceptance takes priority over a same-cycle request and tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int unsigned d = 0; d < N_DIR; d++) begin
        age[d] <= '0;
      end
    end else begin
      pending <= (pending | req_i) & ~clr_mask;
      for (int unsigned d = 0; d < N_DIR; d++) begin
        if (!pending[d] || clr_mask[d]) begin
          age[d] <= '0;
        end else if (tick && (age[d] != AGE_MAX)) begin
          age[d] <= age[d] + 1'b1;
        end
      end
    end
  end

  rr_pick4 u_pick_urgent (
    .req   (urgent),
    .ptr   (last_dir),
    .found (u_found),
    .idx   (u_idx)
  );

  rr_pick4 u_pick_pending (
    .req   (pending),
    .ptr   (last_dir),
    .found (p_found),
    .idx   (p_idx)
  );

  assign sel_dir    = u_found ? u_idx : p_idx;
  assign sel_urgent = u_found;

`ifdef TRAFFIC_PREEMPT_EN
  logic preempted;

  // An emergency grant must not disturb the round-robin position.
  assign update_ptr = !preempted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preempted <= 1'b0;
    end else if (state == IDLE) begin
      preempted <= preempt_i;
    end
  end
`else
  assign update_ptr = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_dir       <= 2'd3;
      grant_valid_o  <= 1'b0;
      grant_dir_o    <= '0;
      grant_urgent_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
`ifdef TRAFFIC_PREEMPT_EN
          if (preempt_i) begin
            state          <= OFFER;
            grant_valid_o  <= 1'b1;
            grant_dir_o    <= preempt_dir_i;
            grant_urgent_o <= 1'b1;
          end else
`endif
          if (p_found) begin
            state          <= OFFER;
            grant_valid_o  <= 1'b1;
            grant_dir_o    <= sel_dir;
            grant_urgent_o <= sel_urgent;
          end
        end
        OFFER: begin
          if (grant_ready_i) begin
            state         <= SERVE;
            grant_valid_o <= 1'b0;
            busy_o        <= 1'b1;
            if (update_ptr) begin
              last_dir <= grant_dir_o;
            end
          end
        end
        SERVE: begin
          if (phase_done_i) begin
            state          <= IDLE;
            busy_o         <= 1'b0;
            grant_urgent_o <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          grant_valid_o  <= 1'b0;
          grant_urgent_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule
